// File: rtl/result_merge_pkg.sv
// Shared constants for the result merge block and the downstream routing demux.
// The source encoding doubles as the demux select value.
package result_merge_pkg;

    localparam int DATA_W_DEFAULT = 32;

    typedef enum logic {
        SRC_ALU    = 1'b0,
        SRC_BUFFER = 1'b1
    } src_e;

endpackage

// File: rtl/merge_slot.sv
// Single-entry holding register with a full flag.
// A load on the same edge as a pop wins, so the slot stays full with the new word.
module merge_slot
    import result_merge_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_pop,
    output logic              o_full,
    output logic [DATA_W-1:0] o_data
);

    logic              r_full;
    logic [DATA_W-1:0] r_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_full <= 1'b0;
            r_data <= '0;
        end else if (i_load) begin
            r_full <= 1'b1;
            r_data <= i_data;
        end else if (i_pop) begin
            r_full <= 1'b0;
        end
    end

    assign o_full = r_full;
    assign o_data = r_data;

endmodule

// File: rtl/result_merge.sv
// Two-source merge (ALU, Buffer) into one writeback stream, one slot per source.
// Define RESULT_MERGE_RR_EN for round-robin arbitration; otherwise the ALU has fixed priority.
module result_merge
    import result_merge_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] InAlu,
    input  logic              InAluValid,
    output logic              InAluReady,
    input  logic [DATA_W-1:0] InBuffer,
    input  logic              InBufferValid,
    output logic              InBufferReady,
    output logic [DATA_W-1:0] Out,
    output logic              OutValid,
    input  logic              OutReady,
    output logic              OutSrc
);

    logic              w_aluFull;
    logic              w_bufFull;
    logic [DATA_W-1:0] w_aluData;
    logic [DATA_W-1:0] w_bufData;
    logic              w_aluLoad;
    logic              w_bufLoad;
    logic              w_aluPop;
    logic              w_bufPop;
    logic              w_outFire;
    logic              w_aluGrant;
    logic              w_bufGrant;
    src_e              w_arbSrc;
    src_e              w_grantSrc;
    logic              r_stalled;
    src_e              r_stallSrc;

`ifdef RESULT_MERGE_RR_EN
    src_e r_nextSrc;

    always_comb begin
        w_arbSrc = SRC_ALU;
        if (w_aluFull && w_bufFull) begin
            w_arbSrc = r_nextSrc;
        end else if (w_bufFull) begin
            w_arbSrc = SRC_BUFFER;
        end
    end

    // Pointer names the source to favour on the next tie; it moves only on output transfers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_nextSrc <= SRC_ALU;
        end else if (w_outFire) begin
            r_nextSrc <= (w_grantSrc == SRC_ALU) ? SRC_BUFFER : SRC_ALU;
        end
    end
`else
    always_comb begin
        w_arbSrc = SRC_ALU;
        if (w_bufFull && !w_aluFull) begin
            w_arbSrc = SRC_BUFFER;
        end
    end
`endif

    // An empty slot may fill during a stall; the lock keeps the presented word from switching.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stalled  <= 1'b0;
            r_stallSrc <= SRC_ALU;
        end else begin
            r_stalled  <= OutValid && !OutReady;
            r_stallSrc <= w_grantSrc;
        end
    end

    assign w_grantSrc = r_stalled ? r_stallSrc : w_arbSrc;

    assign OutValid   = w_aluFull || w_bufFull;
    assign w_outFire  = OutValid && OutReady;
    assign w_aluGrant = OutValid && (w_grantSrc == SRC_ALU);
    assign w_bufGrant = OutValid && (w_grantSrc == SRC_BUFFER);

    assign InAluReady    = !w_aluFull || (w_aluGrant && OutReady);
    assign InBufferReady = !w_bufFull || (w_bufGrant && OutReady);

    assign w_aluLoad = InAluValid && InAluReady;
    assign w_bufLoad = InBufferValid && InBufferReady;
    assign w_aluPop  = w_outFire && w_aluGrant;
    assign w_bufPop  = w_outFire && w_bufGrant;

    assign Out    = w_bufGrant ? w_bufData : (w_aluGrant ? w_aluData : '0);
    assign OutSrc = w_bufGrant;

    merge_slot #(.DATA_W(DATA_W)) u_aluSlot (
        .clk    (clk),
        .reset  (reset),
        .i_load (w_aluLoad),
        .i_data (InAlu),
        .i_pop  (w_aluPop),
        .o_full (w_aluFull),
        .o_data (w_aluData)
    );

    merge_slot #(.DATA_W(DATA_W)) u_bufSlot (
        .clk    (clk),
        .reset  (reset),
        .i_load (w_bufLoad),
        .i_data (InBuffer),
        .i_pop  (w_bufPop),
        .o_full (w_bufFull),
        .o_data (w_bufData)
    );

endmodule

// File: tb/tb_result_merge.sv
// Self-checking bench for result_merge: directed scenarios plus a randomized run against a queue model.
// Builds in either arbitration mode, selected by RESULT_MERGE_RR_EN.
module tb_result_merge;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] InAlu;
    logic         InAluValid;
    logic         InAluReady;
    logic [W-1:0] InBuffer;
    logic         InBufferValid;
    logic         InBufferReady;
    logic [W-1:0] Out;
    logic         OutValid;
    logic         OutReady;
    logic         OutSrc;

    int nChecks = 0;
    int nFails  = 0;

    always #5 clk = ~clk;

    result_merge #(.DATA_W(W)) dut (
        .clk           (clk),
        .reset         (reset),
        .InAlu         (InAlu),
        .InAluValid    (InAluValid),
        .InAluReady    (InAluReady),
        .InBuffer      (InBuffer),
        .InBufferValid (InBufferValid),
        .InBufferReady (InBufferReady),
        .Out           (Out),
        .OutValid      (OutValid),
        .OutReady      (OutReady),
        .OutSrc        (OutSrc)
    );

    task automatic drive(input logic av, input logic [W-1:0] a, input logic bv,
                         input logic [W-1:0] b, input logic ordy);
        InAluValid    = av;
        InAlu         = a;
        InBufferValid = bv;
        InBuffer      = b;
        OutReady      = ordy;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        drive(1'b0, '0, 1'b0, '0, 1'b0);
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        drive(1'b0, '0, 1'b0, '0, 1'b0);
        reset = 1'b0;
        #1 reset = 1'b1;
        #2;
        nChecks++;
        if (OutValid !== 1'b0) begin nFails++; $display("FAIL reset_outvalid: got %b want 0", OutValid); end
        nChecks++;
        if (Out !== '0) begin nFails++; $display("FAIL reset_out: got %h want 0", Out); end
        nChecks++;
        if (OutSrc !== 1'b0) begin nFails++; $display("FAIL reset_outsrc: got %b want 0", OutSrc); end
        nChecks++;
        if (InAluReady !== 1'b1 || InBufferReady !== 1'b1) begin
            nFails++;
            $display("FAIL reset_readies: got alu=%b buf=%b want 1/1", InAluReady, InBufferReady);
        end
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_single_alu();
        doReset();
        drive(1'b1, 32'h0000_00A5, 1'b0, '0, 1'b1);
        @(negedge clk);
        nChecks++;
        if (InAluReady !== 1'b1) begin nFails++; $display("FAIL single_ready: got %b want 1", InAluReady); end
        tick();
        drive(1'b0, '0, 1'b0, '0, 1'b1);
        @(negedge clk);
        nChecks++;
        if (OutValid !== 1'b1 || Out !== 32'h0000_00A5 || OutSrc !== 1'b0) begin
            nFails++;
            $display("FAIL single_out: got v=%b d=%h s=%b want v=1 d=000000a5 s=0", OutValid, Out, OutSrc);
        end
        tick();
        @(negedge clk);
        nChecks++;
        if (OutValid !== 1'b0 || Out !== '0) begin
            nFails++;
            $display("FAIL single_once: got v=%b d=%h want v=0 d=0", OutValid, Out);
        end
    endtask

    task automatic test_interleave();
        int           ai = 0;
        int           bi = 0;
        int           got = 0;
        logic         aluAcc;
        logic         bufAcc;
        logic [W-1:0] gotData [8];
        logic         gotSrc  [8];
        logic [W-1:0] expData;
        logic         expSrc;
        doReset();
        for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
            drive(ai < 4, 32'h1 + ai, bi < 4, 32'h100 + bi, 1'b1);
            @(negedge clk);
            aluAcc = InAluValid && InAluReady;
            bufAcc = InBufferValid && InBufferReady;
            if (OutValid === 1'b1) begin
                gotData[got] = Out;
                gotSrc[got]  = OutSrc;
                got++;
            end
            tick();
            if (aluAcc) ai++;
            if (bufAcc) bi++;
        end
        drive(1'b0, '0, 1'b0, '0, 1'b1);
        nChecks++;
        if (got != 8) begin nFails++; $display("FAIL interleave_count: got %0d words want 8", got); end
        for (int k = 0; k < got; k++) begin
`ifdef RESULT_MERGE_RR_EN
            expSrc  = k[0];
            expData = expSrc ? (32'h100 + k / 2) : (32'h1 + k / 2);
`else
            expSrc  = (k >= 4);
            expData = expSrc ? (32'h100 + k - 4) : (32'h1 + k);
`endif
            nChecks++;
            if (gotData[k] !== expData || gotSrc[k] !== expSrc) begin
                nFails++;
                $display("FAIL interleave_%0d: got d=%h s=%b want d=%h s=%b", k, gotData[k], gotSrc[k], expData, expSrc);
            end
        end
        tick();
    endtask

    task automatic test_stall();
        doReset();
        drive(1'b1, 32'hDEAD_BEEF, 1'b1, 32'h77, 1'b0);
        tick();
        drive(1'b0, '0, 1'b1, 32'h88, 1'b0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            nChecks++;
            if (OutValid !== 1'b1 || Out !== 32'hDEAD_BEEF || OutSrc !== 1'b0 || InBufferReady !== 1'b0) begin
                nFails++;
                $display("FAIL stall_%0d: got v=%b d=%h s=%b brdy=%b want v=1 d=deadbeef s=0 brdy=0",
                         c, OutValid, Out, OutSrc, InBufferReady);
            end
            tick();
        end
        drive(1'b0, '0, 1'b0, '0, 1'b1);
        @(negedge clk);
        nChecks++;
        if (OutValid !== 1'b1 || Out !== 32'hDEAD_BEEF) begin
            nFails++;
            $display("FAIL stall_release: got v=%b d=%h want v=1 d=deadbeef", OutValid, Out);
        end
        tick();
        @(negedge clk);
        nChecks++;
        if (OutValid !== 1'b1 || Out !== 32'h77 || OutSrc !== 1'b1) begin
            nFails++;
            $display("FAIL stall_buffer: got v=%b d=%h s=%b want v=1 d=00000077 s=1", OutValid, Out, OutSrc);
        end
        tick();
        @(negedge clk);
        nChecks++;
        if (OutValid !== 1'b0) begin nFails++; $display("FAIL stall_drained: got v=%b want 0", OutValid); end
    endtask

    task automatic test_refill();
        doReset();
        drive(1'b0, '0, 1'b1, 32'h33, 1'b1);
        tick();
        drive(1'b0, '0, 1'b1, 32'h55, 1'b1);
        @(negedge clk);
        nChecks++;
        if (OutValid !== 1'b1 || Out !== 32'h33 || OutSrc !== 1'b1 || InBufferReady !== 1'b1) begin
            nFails++;
            $display("FAIL refill_first: got v=%b d=%h s=%b brdy=%b want v=1 d=00000033 s=1 brdy=1",
                     OutValid, Out, OutSrc, InBufferReady);
        end
        tick();
        drive(1'b0, '0, 1'b0, '0, 1'b1);
        @(negedge clk);
        nChecks++;
        if (OutValid !== 1'b1 || Out !== 32'h55 || OutSrc !== 1'b1) begin
            nFails++;
            $display("FAIL refill_next: got v=%b d=%h s=%b want v=1 d=00000055 s=1", OutValid, Out, OutSrc);
        end
        tick();
        @(negedge clk);
        nChecks++;
        if (OutValid !== 1'b0) begin nFails++; $display("FAIL refill_drained: got v=%b want 0", OutValid); end
    endtask

    task automatic test_reset_midstream();
        doReset();
        drive(1'b1, 32'h11, 1'b1, 32'h22, 1'b0);
        tick();
        drive(1'b0, '0, 1'b0, '0, 1'b0);
        @(negedge clk);
        nChecks++;
        if (OutValid !== 1'b1 || InAluReady !== 1'b0 || InBufferReady !== 1'b0) begin
            nFails++;
            $display("FAIL midreset_full: got v=%b ardy=%b brdy=%b want 1/0/0", OutValid, InAluReady, InBufferReady);
        end
        #2 reset = 1'b1;
        #1;
        nChecks++;
        if (OutValid !== 1'b0 || Out !== '0 || InAluReady !== 1'b1 || InBufferReady !== 1'b1) begin
            nFails++;
            $display("FAIL midreset_async: got v=%b d=%h ardy=%b brdy=%b want 0/0/1/1",
                     OutValid, Out, InAluReady, InBufferReady);
        end
        tick();
        reset = 1'b0;
        drive(1'b0, '0, 1'b0, '0, 1'b1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            nChecks++;
            if (OutValid !== 1'b0) begin
                nFails++;
                $display("FAIL midreset_stale_%0d: got v=%b d=%h want v=0", c, OutValid, Out);
            end
            tick();
        end
    endtask

    task automatic test_random();
        logic [W-1:0] qA[$];
        logic [W-1:0] qB[$];
        logic         lastServed = 1'b1;
        logic         held = 1'b0;
        logic         heldSrc = 1'b0;
        logic         av, bv, ordy, expValid, grant, expARdy, expBRdy;
        logic [W-1:0] a, b, expOut;
        doReset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            av   = 1'($urandom_range(0, 1));
            bv   = 1'($urandom_range(0, 1));
            ordy = ($urandom_range(0, 3) != 0);
            a    = $urandom;
            b    = $urandom;
            drive(av, a, bv, b, ordy);
            expValid = (qA.size() + qB.size()) > 0;
            if (!expValid)              grant = 1'b0;
            else if (held)              grant = heldSrc;
            else if (qA.size() == 0)    grant = 1'b1;
            else if (qB.size() == 0)    grant = 1'b0;
`ifdef RESULT_MERGE_RR_EN
            else                        grant = !lastServed;
`else
            else                        grant = 1'b0;
`endif
            expOut  = !expValid ? '0 : (grant ? qB[0] : qA[0]);
            expARdy = (qA.size() == 0) || (expValid && !grant && ordy);
            expBRdy = (qB.size() == 0) || (expValid && grant && ordy);
            @(negedge clk);
            nChecks++;
            if (OutValid !== expValid || Out !== expOut || OutSrc !== (expValid & grant)) begin
                nFails++;
                $display("FAIL random_out_%0d: got v=%b d=%h s=%b want v=%b d=%h s=%b",
                         cyc, OutValid, Out, OutSrc, expValid, expOut, expValid & grant);
            end
            nChecks++;
            if (InAluReady !== expARdy || InBufferReady !== expBRdy) begin
                nFails++;
                $display("FAIL random_ready_%0d: got ardy=%b brdy=%b want ardy=%b brdy=%b",
                         cyc, InAluReady, InBufferReady, expARdy, expBRdy);
            end
            tick();
            if (expValid && ordy) begin
                if (grant) void'(qB.pop_front());
                else       void'(qA.pop_front());
                lastServed = grant;
            end
            if (av && expARdy) qA.push_back(a);
            if (bv && expBRdy) qB.push_back(b);
            held    = expValid && !ordy;
            heldSrc = grant;
        end
        drive(1'b0, '0, 1'b0, '0, 1'b1);
        tick();
        tick();
        tick();
    endtask

    initial begin
        test_reset();
        test_single_alu();
        test_interleave();
        test_stall();
        test_refill();
        test_reset_midstream();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

    initial begin
        #200000;
        nFails++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $fatal(1, "[TB] time limit");
    end

endmodule

// File: doc/result_merge.md
RESULT_MERGE -- requirements
Module: result_merge

Interface
REQ-001 SHALL have parameter DATA_W, default 32, width of every data path.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port InAlu  input  DATA_W  result word from the ALU path.
REQ-005 SHALL have port InAluValid  input  1  InAlu holds a word to deliver.
REQ-006 SHALL have port InAluReady  output  1  merge accepts InAlu this cycle.
REQ-007 SHALL have port InBuffer  input  DATA_W  word from the Buffer path.
REQ-008 SHALL have port InBufferValid  input  1  InBuffer holds a word to deliver.
REQ-009 SHALL have port InBufferReady  output  1  merge accepts InBuffer this cycle.
REQ-010 SHALL have port Out  output  DATA_W  merged word toward writeback.
REQ-011 SHALL have port OutValid  output  1  Out holds a valid word.
REQ-012 SHALL have port OutReady  input  1  consumer accepts Out this cycle.
REQ-013 SHALL have port OutSrc  output  1  source of Out: 0 = ALU, 1 = Buffer, the same encoding as the routing select op.

Function
REQ-014 SHALL hold one single-entry slot per source (ALU slot, Buffer slot), each with a full flag.
REQ-015 SHALL transfer on a port exactly when its valid and ready are both high at a rising clk edge.
REQ-016 SHALL drive InXReady = !slotX_full || (slotX granted && OutReady); a full slot and an empty slot refill in the same cycle.
REQ-017 SHALL assert OutValid whenever at least one slot is full; Out and OutSrc come from the granted slot.
REQ-018 SHALL drive Out = 0 and OutSrc = 0 when OutValid is low.
REQ-019 SHALL make a word accepted at edge N visible on Out after edge N (1-cycle latency) when its slot is granted.
REQ-020 SHALL, with only one slot full, grant that slot.
REQ-021 SHALL, with both slots full, grant per the arbitration policy of REQ-028/REQ-029.
REQ-022 SHALL hold Out, OutSrc and OutValid stable while OutValid && !OutReady; the grant must not change while stalled.
REQ-023 SHALL clear the granted slot on an output transfer, unless the same edge refills it, in which case it stays full with the new word.
REQ-024 SHALL never drop, duplicate or reorder words within one source.

Reset
REQ-025 SHALL, while reset is high, immediately clear both full flags and set the arbitration pointer to "ALU next".
REQ-026 SHALL, while reset is high, force OutValid = 0, Out = 0, OutSrc = 0, and InAluReady = InBufferReady = 1.
REQ-027 SHALL discard any word held at reset assertion mid-operation; no transfer completes on an edge where reset is high.

Configuration
REQ-028 SHALL, with RESULT_MERGE_RR_EN defined, use round-robin arbitration:
- with both slots full, grant the source not served by the last output transfer;
- update the pointer only on output transfers.
REQ-029 SHALL, without RESULT_MERGE_RR_EN, use fixed priority: ALU always wins when both slots are full, and no pointer register exists.

Structure
REQ-030 SHALL place in shared package result_merge_pkg:
- the DATA_W default;
- the source encoding constants SRC_ALU = 0 and SRC_BUFFER = 1, shared with the routing demux select.
REQ-031 SHALL implement each slot as an instance of sub-module merge_slot: one-entry register with full flag, load and pop inputs, and asynchronous reset.

Verification
REQ-032 SHALL cover: reset asserted mid-stream with both slots full -> OutValid = 0 and both readies = 1 immediately; no stale word appears after release.
REQ-033 SHALL cover: InAlu = 0x0000_00A5 valid one cycle, OutReady = 1 -> next cycle Out = 0x0000_00A5, OutSrc = 0, OutValid = 1 for one cycle.
REQ-034 SHALL cover: both sources valid every cycle, ALU 0x1..0x4 and Buffer 0x100..0x103, OutReady = 1 ->
- with RESULT_MERGE_RR_EN: output alternates ALU, Buffer, ALU, Buffer, starting with ALU;
- without it: all four ALU words first, then the Buffer words.
REQ-035 SHALL cover: OutReady = 0 for 5 cycles with Out = 0xDEAD_BEEF -> Out, OutSrc and OutValid constant; InBufferReady = 0 once the Buffer slot is full.
REQ-036 SHALL cover: Buffer slot full and granted, OutReady = 1, new InBuffer = 0x55 valid on the same edge -> InBufferReady = 1, 0x55 presented on the next cycle, no bubble.
